// File: rtl/cdclib_pkg.sv
// Shared cdclib definitions: handshake sequencer state encoding and a
// constant-evaluable ceiling-log2 helper for sizing index and counter fields.
package cdclib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } cdclib_arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cdclib_rr_pick.sv
// Combinational round-robin picker: first asserted request found scanning
// upward from ptr with wrap-around.
module cdclib_rr_pick
  import cdclib_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [IDXW-1:0]    win_idx,
  output logic               valid
);

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    win_idx = '0;
    valid   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        win_idx = IDXW'(j);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdclib_lvlsync_arb.sv
// Round-robin arbiter + 4-phase level handshake sequencer (write clock domain).
// Define CDCLIB_LVLSYNC_ARB_TIMEOUT_EN to enable per-phase ack timeout.
module cdclib_lvlsync_arb
  import cdclib_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DWIDTH      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      xfer_req,
  output logic [DWIDTH-1:0]         xfer_data,
  input  logic                      xfer_ack_sync,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  localparam int IDXW = clog2(NUM_REQ);

  cdclib_arb_state_e   r_state, w_state_nxt;
  logic [IDXW-1:0]     r_ptr, r_cur, w_win_idx;
  logic                w_win_vld;
  logic [DWIDTH-1:0]   r_xfer_data, w_win_data;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic                r_xfer_req, r_busy;
  logic                w_launch, w_done, w_to_hit;

  cdclib_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .win_idx (w_win_idx),
    .valid   (w_win_vld)
  );

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == IDXW'(i)) w_win_data = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // A stale high ack blocks launch, so a local reset cannot corrupt the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_vld && !xfer_ack_sync) begin
          w_state_nxt = REQ;
          w_launch    = 1'b1;
        end
      end
      REQ: begin
        if (xfer_ack_sync || w_to_hit) w_state_nxt = REL;
      end
      REL: begin
        if (!xfer_ack_sync || w_to_hit) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt = '0;
    if (w_done) w_gnt_nxt = NUM_REQ'(1) << r_cur;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cur       <= '0;
      r_gnt       <= '0;
      r_xfer_req  <= 1'b0;
      r_xfer_data <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_xfer_req <= (w_state_nxt == REQ);
      r_busy     <= (w_state_nxt != IDLE);
      if (w_launch) begin
        r_cur       <= w_win_idx;
        r_xfer_data <= w_win_data;
      end
      if (w_done) r_ptr <= (r_cur == IDXW'(NUM_REQ - 1)) ? '0 : r_cur + 1'b1;
    end
  end

`ifdef CDCLIB_LVLSYNC_ARB_TIMEOUT_EN
  localparam int CNTW = clog2(ACK_TIMEOUT + 1);

  logic [CNTW-1:0] r_cnt, w_cnt_inc;
  logic            r_timeout_err;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_to_hit  = (r_state != IDLE) && (w_cnt_inc == CNTW'(ACK_TIMEOUT));

  // Phase counter restarts on every state change; a timeout outranks err_clr.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state != IDLE)   r_cnt <= w_cnt_inc;
      if (w_to_hit)     r_timeout_err <= 1'b1;
      else if (err_clr) r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused;

  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
  assign w_unused    = err_clr ^ (ACK_TIMEOUT == 0);
`endif

  assign gnt       = r_gnt;
  assign xfer_req  = r_xfer_req;
  assign xfer_data = r_xfer_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cdclib_lvlsync_arb.sv
// Directed bench for cdclib_lvlsync_arb: per-cycle vector table plus
// hand-written fairness, stale-ack, reset and timeout sequences.
module tb_cdclib_lvlsync_arb;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            wr_clk = 1'b0;
  logic            wr_rst_n;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   gnt;
  logic            xfer_req;
  logic [DW-1:0]   xfer_data;
  logic            xfer_ack_sync;
  logic            busy;
  logic            timeout_err;
  logic            err_clr;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       xreq;
    logic [7:0] xdata;
    logic [3:0] gnt;
    logic       busy;
  } vec_t;

  vec_t tbl [28];

  always #5 wr_clk = ~wr_clk;

  cdclib_lvlsync_arb #(
    .NUM_REQ     (NR),
    .DWIDTH      (DW),
    .ACK_TIMEOUT (10)
  ) dut (
    .wr_clk        (wr_clk),
    .wr_rst_n      (wr_rst_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .xfer_req      (xfer_req),
    .xfer_data     (xfer_data),
    .xfer_ack_sync (xfer_ack_sync),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .err_clr       (err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    @(negedge wr_clk);
  endtask

  task automatic wait_xreq(input logic v, input string tag);
    int k;
    k = 0;
    while (xfer_req !== v && k < 20) begin
      step();
      k++;
    end
    chk({tag, " xfer_req"}, 32'(xfer_req), 32'(v));
  endtask

  task automatic wait_gnt(input logic [3:0] exp, input string tag);
    int k;
    k = 0;
    while (gnt === 4'b0000 && k < 20) begin
      step();
      k++;
    end
    chk({tag, " gnt"}, 32'(gnt), 32'(exp));
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    step();
    wr_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req           = '0;
    req_data      = {8'hD3, 8'hA5, 8'h5C, 8'h1E};
    xfer_ack_sync = 1'b0;
    err_clr       = 1'b0;
    wr_rst_n      = 1'b0;

    //          req      ack   xreq  xdata  gnt      busy
    tbl[0]  = '{4'b0100, 1'b0, 1'b1, 8'hA5, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 8'hA5, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 8'hA5, 4'b0000, 1'b1};
    tbl[3]  = '{4'b0100, 1'b1, 1'b0, 8'hA5, 4'b0000, 1'b1};
    tbl[4]  = '{4'b0100, 1'b1, 1'b0, 8'hA5, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0100, 1'b1, 1'b0, 8'hA5, 4'b0000, 1'b1};
    tbl[6]  = '{4'b0100, 1'b0, 1'b0, 8'hA5, 4'b0100, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 8'hA5, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1111, 1'b0, 1'b1, 8'hD3, 4'b0000, 1'b1};
    tbl[9]  = '{4'b1111, 1'b1, 1'b0, 8'hD3, 4'b0000, 1'b1};
    tbl[10] = '{4'b1111, 1'b0, 1'b0, 8'hD3, 4'b1000, 1'b0};
    tbl[11] = '{4'b0111, 1'b0, 1'b1, 8'h1E, 4'b0000, 1'b1};
    tbl[12] = '{4'b0111, 1'b1, 1'b0, 8'h1E, 4'b0000, 1'b1};
    tbl[13] = '{4'b0111, 1'b0, 1'b0, 8'h1E, 4'b0001, 1'b0};
    tbl[14] = '{4'b0110, 1'b0, 1'b1, 8'h5C, 4'b0000, 1'b1};
    tbl[15] = '{4'b0100, 1'b0, 1'b1, 8'h5C, 4'b0000, 1'b1};
    tbl[16] = '{4'b0100, 1'b1, 1'b0, 8'h5C, 4'b0000, 1'b1};
    tbl[17] = '{4'b0100, 1'b0, 1'b0, 8'h5C, 4'b0010, 1'b0};
    tbl[18] = '{4'b0100, 1'b0, 1'b1, 8'hA5, 4'b0000, 1'b1};
    tbl[19] = '{4'b0100, 1'b1, 1'b0, 8'hA5, 4'b0000, 1'b1};
    tbl[20] = '{4'b0100, 1'b0, 1'b0, 8'hA5, 4'b0100, 1'b0};
    tbl[21] = '{4'b0000, 1'b0, 1'b0, 8'hA5, 4'b0000, 1'b0};
    tbl[22] = '{4'b0001, 1'b1, 1'b0, 8'hA5, 4'b0000, 1'b0};
    tbl[23] = '{4'b0001, 1'b1, 1'b0, 8'hA5, 4'b0000, 1'b0};
    tbl[24] = '{4'b0001, 1'b0, 1'b1, 8'h1E, 4'b0000, 1'b1};
    tbl[25] = '{4'b0001, 1'b1, 1'b0, 8'h1E, 4'b0000, 1'b1};
    tbl[26] = '{4'b0001, 1'b0, 1'b0, 8'h1E, 4'b0001, 1'b0};
    tbl[27] = '{4'b0000, 1'b0, 1'b0, 8'h1E, 4'b0000, 1'b0};

    repeat (2) @(negedge wr_clk);
    chk("reset xfer_req",    32'(xfer_req),    0);
    chk("reset xfer_data",   32'(xfer_data),   0);
    chk("reset gnt",         32'(gnt),         0);
    chk("reset busy",        32'(busy),        0);
    chk("reset timeout_err", 32'(timeout_err), 0);
    wr_rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      req           = tbl[i].req;
      xfer_ack_sync = tbl[i].ack;
      step();
      chk($sformatf("row%0d xfer_req", i),  32'(xfer_req),  32'(tbl[i].xreq));
      chk($sformatf("row%0d xfer_data", i), 32'(xfer_data), 32'(tbl[i].xdata));
      chk($sformatf("row%0d gnt", i),       32'(gnt),       32'(tbl[i].gnt));
      chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].busy));
    end

    // Fairness: all four requesting from a fresh pointer
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      int idx;
      idx = t % 4;
      wait_xreq(1'b1, $sformatf("fair%0d launch", t));
      chk($sformatf("fair%0d xfer_data", t), 32'(xfer_data), 32'(req_data[idx*DW +: DW]));
      xfer_ack_sync = 1'b1;
      wait_xreq(1'b0, $sformatf("fair%0d release", t));
      xfer_ack_sync = 1'b0;
      wait_gnt(4'b0001 << idx, $sformatf("fair%0d", t));
      step();
      chk($sformatf("fair%0d gnt width", t), 32'(gnt), 0);
    end
    req = 4'b0000;
    repeat (3) step();

    // Stale ack held high across reset blocks launch
    xfer_ack_sync = 1'b1;
    req           = 4'b0001;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stale%0d xfer_req", k), 32'(xfer_req), 0);
      step();
    end
    xfer_ack_sync = 1'b0;
    step();
    chk("stale launch xfer_req",  32'(xfer_req),  1);
    chk("stale launch xfer_data", 32'(xfer_data), 32'h1E);

    // Reset while in REQ takes effect without a clock edge
    #2;
    wr_rst_n = 1'b0;
    #1;
    chk("midrst xfer_req",  32'(xfer_req),  0);
    chk("midrst xfer_data", 32'(xfer_data), 0);
    chk("midrst busy",      32'(busy),      0);
    chk("midrst gnt",       32'(gnt),       0);
    req = 4'b0000;
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("midrst%0d gnt", k), 32'(gnt), 0);
    end

`ifdef CDCLIB_LVLSYNC_ARB_TIMEOUT_EN
    begin
      int cnt;
      int k;
      req = 4'b0001;
      step();
      chk("to launch xfer_req", 32'(xfer_req), 1);
      cnt = 0;
      k   = 0;
      while (xfer_req === 1'b1 && k < 40) begin
        cnt++;
        step();
        k++;
      end
      chk("to req cycles", 32'(cnt), 10);
      chk("to timeout_err set", 32'(timeout_err), 1);
      wait_gnt(4'b0001, "to");
      req     = 4'b0000;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("to timeout_err cleared", 32'(timeout_err), 0);
    end
`else
    req = 4'b0001;
    step();
    chk("noto launch xfer_req", 32'(xfer_req), 1);
    repeat (40) step();
    chk("noto still waiting", 32'(xfer_req), 1);
    chk("noto timeout_err", 32'(timeout_err), 0);
    xfer_ack_sync = 1'b1;
    wait_xreq(1'b0, "noto release");
    xfer_ack_sync = 1'b0;
    wait_gnt(4'b0001, "noto");
    req = 4'b0000;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cdclib_lvlsync_arb.md
# cdclib_lvlsync_arb

Round-robin arbiter and 4-phase handshake sequencer that shares one multi-bit level-synchronized channel among several write-domain requesters. It drives a held-stable data word plus a request level toward the read domain, and consumes the acknowledge level returned through a 4-stage level synchronizer. The block sits entirely in the write clock domain, alongside the synchronizer instances that carry `xfer_req` out and `xfer_ack_sync` back.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `DWIDTH`, 8: payload width per requester.
- `ACK_TIMEOUT`, 255: wait limit in cycles per handshake phase. Used only with the timeout feature; legal range 1..65535.

Ports (single clock `wr_clk`; reset `wr_rst_n` is asynchronous, active-low):
- `wr_clk`  in  1  write-domain clock.
- `wr_rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held high until the matching `gnt` bit.
- `req_data`  in  NUM_REQ*DWIDTH  payload; slice i belongs to requester i.
- `gnt`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `xfer_req`  out  1  request level sent to the read domain.
- `xfer_data`  out  DWIDTH  payload sent to the read domain; stable whenever `xfer_req`=1.
- `xfer_ack_sync`  in  1  read-domain acknowledge, already synchronized into `wr_clk`.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky timeout flag.
- `err_clr`  in  1  synchronous clear of `timeout_err`.

## Operation
- FSM states are IDLE, REQ and REL.
- **IDLE:** waits for any `req` bit high while `xfer_ack_sync`=0.
  - Picks the winner i by scanning from priority pointer `ptr` upward, with wrap.
  - Registers `req_data[i]` into `xfer_data` and i into `cur`, and goes to REQ.
  - A stale high ack, for example after a local reset, blocks launch until it falls.
- **REQ:** `xfer_req`=1. When `xfer_ack_sync`=1, go to REL.
- **REL:** `xfer_req`=0. When `xfer_ack_sync`=0:
  - pulse `gnt[cur]`,
  - set `ptr` = (cur+1) mod NUM_REQ,
  - go to IDLE.
- A requester that drops `req` mid-transfer does not abort the transfer; its `gnt` still pulses.
- `xfer_data` changes only on the IDLE→REQ transition.
- `err_clr` and a timeout set in the same cycle: set wins.
- Reset values: state IDLE, `ptr`=0, `cur`=0, `gnt`=0, `xfer_req`=0, `xfer_data`=0, `busy`=0, `timeout_err`=0.
- Reset mid-transfer returns to IDLE immediately. The ack-low launch guard prevents protocol corruption.

## Timing
- `xfer_req` and `xfer_data` are registered outputs with no combinational input-to-output paths.
- Latency:
  - `req` sampled in IDLE at edge n → `xfer_req`=1 after edge n+1.
  - Ack high sampled at edge m → `xfer_req`=0 after edge m+1.
  - Ack low sampled at edge k → `gnt` high for the cycle after edge k+1, and the FSM is in IDLE.
- At least one IDLE cycle separates transfers. Back-to-back launch is therefore at the earliest one cycle after `gnt`.
- `busy` is registered and equals (state != IDLE).
- `gnt` never asserts for more than one cycle and is never multi-hot.

## Configuration
- `CDCLIB_LVLSYNC_ARB_TIMEOUT_EN` defined:
  - A phase counter of width clog2(ACK_TIMEOUT+1) clears on every state change.
  - It increments each cycle spent in REQ or REL.
  - Reaching ACK_TIMEOUT in REQ sets `timeout_err` and forces REL.
  - Reaching ACK_TIMEOUT in REL sets `timeout_err`, pulses `gnt[cur]`, advances `ptr` and goes to IDLE.
- Undefined: no counter; REQ and REL wait indefinitely; `timeout_err` is tied to 0; `err_clr` is ignored.

## Structure
- Shared package `cdclib_pkg` holds:
  - the state enum `cdclib_arb_state_e` (IDLE=2'd0, REQ=2'd1, REL=2'd2),
  - the `clog2` helper function.
- Sub-module `cdclib_rr_pick`: combinational round-robin picker.
  - Inputs: `req` and `ptr`.
  - Outputs: winner index and `valid`.
  - Reused by other cdclib arbiters.
- The top level holds the FSM, pointer, payload register and optional timeout counter.

## Test plan
- **Single request:** `req`=4'b0100, data 8'hA5; ack rises 3 cycles after `xfer_req`, falls 3 cycles after release → `xfer_data`=8'hA5 throughout REQ, `gnt`=4'b0100 for one cycle, `ptr`=3.
- **Fairness:** all four `req` held high for 8 transfers → grant order 0,1,2,3,0,1,2,3, with no starvation.
- **Stale ack:** reset with `xfer_ack_sync` held high and `req`=4'b0001 → no `xfer_req` until ack falls, then launch the next cycle.
- **Mid-operation reset:** assert `wr_rst_n` in REQ → outputs return to reset values within the same cycle; `gnt` stays 0.
- **Timeout (macro on, ACK_TIMEOUT=10):** ack never rises → `xfer_req` drops after 10 cycles in REQ, `timeout_err`=1, `gnt` pulses; `err_clr` → 0 the next cycle.
- **Requester withdraws:** `req[1]` drops during REQ → transfer completes and `gnt[1]` still pulses.
